addsub_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one add/subtract datapath among N requesters.
- The datapath is built from automatic void functions: one adder and one subtractor, both on 32-bit int operands.
- Each requester presents an opcode and two int operands. The block grants one requester at a time, computes the result, and holds it in an output register until the consumer accepts it.
- Sits between the client modules and a single result consumer in the top-level integration.

---
 rtl/addsub_arb_pkg.sv | 40 ++++
 rtl/addsub_arbiter_rr_pick.sv | 35 +++
 rtl/addsub_arbiter.sv | 114 +++++++++++
 tb/tb_addsub_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/addsub_arb_pkg.sv
// Shared types and arithmetic helpers for addsub_arbiter.
// Optional build macro ADDSUB_ARB_SAT_EN: when defined, adder/subtractor
// saturate on signed overflow instead of wrapping.
package addsub_arb_pkg;

    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_t;
    typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

    localparam int INT_MAX = 32'sh7FFF_FFFF;
    localparam int INT_MIN = 32'sh8000_0000;

    // a + b; overflow only when both operands share a sign the sum lacks
    function automatic void adder(input int i_a, input int i_b, output int o);
        int s;
        s = i_a + i_b;
`ifdef ADDSUB_ARB_SAT_EN
        if ((i_a[31] == i_b[31]) && (s[31] != i_a[31]))
            o = i_a[31] ? INT_MIN : INT_MAX;
        else
            o = s;
`else
        o = s;
`endif
    endfunction

    // a - b; overflow only when operand signs differ and result sign leaves a's
    function automatic void subtractor(input int i_a, input int i_b, output int o);
        int d;
        d = i_a - i_b;
`ifdef ADDSUB_ARB_SAT_EN
        if ((i_a[31] != i_b[31]) && (d[31] != i_a[31]))
            o = i_a[31] ? INT_MIN : INT_MAX;
        else
            o = d;
`else
        o = d;
`endif
    endfunction

endpackage

// File: rtl/addsub_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above the
// pointer, wrapping modulo N. Returns one-hot grant, index and a hit flag.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_win,
    output logic           o_any
);

    // Scan N positions starting at the pointer; the first hit wins
    always_comb begin
        int             k;
        logic [IDW-1:0] kk;
        o_gnt = '0;
        o_win = '0;
        o_any = 1'b0;
        k     = 0;
        kk    = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(i_ptr) + i;
            if (k >= N) k = k - N;
            kk = IDW'(k);
            if (!o_any && i_req[kk]) begin
                o_any     = 1'b1;
                o_gnt[kk] = 1'b1;
                o_win     = kk;
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/subtract datapath among N requesters.
// The granted request is computed in the accept cycle and registered, so
// the result appears one cycle after the grant and is held until i_rdy.
// Build macro ADDSUB_ARB_SAT_EN selects saturating arithmetic.
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      i_req,
    input  logic [N-1:0]      i_op,
    input  logic [N*32-1:0]   i_a,
    input  logic [N*32-1:0]   i_b,
    output logic [N-1:0]      o_gnt,
    output logic              o_valid,
    output logic [IDW-1:0]    o_id,
    output logic [31:0]       o_res,
    input  logic              i_rdy
);

    localparam logic [IDW-1:0] LAST = IDW'(N - 1);

    state_t         state_q;
    logic           valid_q;
    logic [IDW-1:0] id_q;
    logic [31:0]    res_q;
    logic [IDW-1:0] ptr_q;

    logic [N-1:0]   pick_gnt;
    logic [IDW-1:0] pick_win;
    logic           pick_any;

    logic           accept_ok;
    logic           accept;
    logic [31:0]    a_sel;
    logic [31:0]    b_sel;
    op_t            op_sel;
    logic [31:0]    res_d;
    logic [IDW-1:0] ptr_d;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .i_req (i_req),
        .i_ptr (ptr_q),
        .o_gnt (pick_gnt),
        .o_win (pick_win),
        .o_any (pick_any)
    );

    // A new operation may enter when idle, or when the held result leaves
    always_comb begin
        accept_ok = (state_q == ST_IDLE) || i_rdy;
        accept    = !i_rst && accept_ok && pick_any;
    end

    assign o_gnt = accept ? pick_gnt : '0;

    // Steer the winner's opcode and operands into the shared datapath
    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = OP_ADD;
        for (int k = 0; k < N; k++) begin
            if (pick_win == IDW'(k)) begin
                a_sel  = i_a[32*k +: 32];
                b_sel  = i_b[32*k +: 32];
                op_sel = op_t'(i_op[k]);
            end
        end
    end

    // Shared adder/subtractor; both evaluated, opcode selects the result
    always_comb begin
        int sum;
        int diff;
        sum  = 0;
        diff = 0;
        adder(int'(a_sel), int'(b_sel), sum);
        subtractor(int'(a_sel), int'(b_sel), diff);
        res_d = (op_sel == OP_SUB) ? diff : sum;
    end

    // Pointer moves to the slot just past the winner
    always_comb begin
        ptr_d = (pick_win == LAST) ? '0 : pick_win + 1'b1;
    end

    // Control FSM with registered result, id, valid and pointer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            res_q   <= '0;
            ptr_q   <= '0;
        end else if (accept) begin
            state_q <= ST_HOLD;
            valid_q <= 1'b1;
            id_q    <= pick_win;
            res_q   <= res_d;
            ptr_q   <= ptr_d;
        end else if ((state_q == ST_HOLD) && i_rdy) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
        end
    end

    assign o_valid = valid_q;
    assign o_id    = id_q;
    assign o_res   = res_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (N=4): inputs change on the falling
// edge, outputs are checked 1ns later, expected values are hand-computed.
module tb_addsub_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    op;
    logic [N*32-1:0] a;
    logic [N*32-1:0] b;
    logic [N-1:0]    gnt;
    logic            valid;
    logic [1:0]      id;
    logic [31:0]     res;
    logic            rdy;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef ADDSUB_ARB_SAT_EN
    localparam logic [31:0] EXP_ADD_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_SUB_OVF = 32'h8000_0000;
`else
    localparam logic [31:0] EXP_ADD_OVF = 32'h8000_0000;
    localparam logic [31:0] EXP_SUB_OVF = 32'h7FFF_FFFF;
`endif

    addsub_arbiter #(.N(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .o_gnt   (gnt),
        .o_valid (valid),
        .o_id    (id),
        .o_res   (res),
        .i_rdy   (rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setop(input int k, input logic o, input logic [31:0] av, input logic [31:0] bv);
        op[k]          = o;
        a[32*k +: 32]  = av;
        b[32*k +: 32]  = bv;
    endtask

    initial begin
        logic [3:0] eg;
        clk = 1'b0; rst = 1'b1; req = '0; op = '0; a = '0; b = '0; rdy = 1'b1;

        // Reset: no grant even with every request up
        @(negedge clk); req = 4'b1111;
        #1 chk("rst_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        #1 chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_id", 32'(id), 32'h0);
        chk("rst_res", res, 32'h0);

        // Single add on requester 2
        @(negedge clk); rst = 1'b0; req = 4'b0100; setop(2, 1'b0, 32'd5, 32'd7);
        #1 chk("t1_gnt", 32'(gnt), 32'h4);
        @(negedge clk); req = 4'b0000;
        #1 chk("t1_valid", 32'(valid), 32'h1);
        chk("t1_id", 32'(id), 32'h2);
        chk("t1_res", res, 32'd12);
        chk("t1_gnt_off", 32'(gnt), 32'h0);
        @(negedge clk);
        #1 chk("t1_idle", 32'(valid), 32'h0);

        // Reset pulse, then all four requesting back-to-back
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < N; k++) setop(k, 1'b0, 32'(10*k + 1), 32'(k));
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            eg = 4'b0001 << (i % 4);
            #1 chk("t2_gnt", 32'(gnt), 32'(eg));
            if (i > 0) begin
                chk("t2_valid", 32'(valid), 32'h1);
                chk("t2_id", 32'(id), 32'((i - 1) % 4));
                chk("t2_res", res, 32'(11*((i - 1) % 4) + 1));
            end
            @(negedge clk);
        end
        req = 4'b0000;
        #1 chk("t2_last_id", 32'(id), 32'h0);
        chk("t2_last_res", res, 32'd1);
        @(negedge clk);
        #1 chk("t2_idle", 32'(valid), 32'h0);

        // Subtract with consumer stalled for three cycles
        @(negedge clk); req = 4'b0010; setop(1, 1'b1, 32'd3, 32'd10);
        #1 chk("t3_gnt", 32'(gnt), 32'h2);
        @(negedge clk); req = 4'b0001; setop(0, 1'b0, 32'd100, 32'd1); rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_stall_gnt", 32'(gnt), 32'h0);
            chk("t3_stall_valid", 32'(valid), 32'h1);
            chk("t3_stall_id", 32'(id), 32'h1);
            chk("t3_stall_res", res, 32'hFFFF_FFF9);
            @(negedge clk);
        end
        rdy = 1'b1;
        #1 chk("t3_rdy_gnt", 32'(gnt), 32'h1);
        @(negedge clk); req = 4'b0000;
        #1 chk("t3_next_id", 32'(id), 32'h0);
        chk("t3_next_res", res, 32'd101);
        @(negedge clk);
        #1 chk("t3_idle", 32'(valid), 32'h0);

        // Overflow on add and subtract
        @(negedge clk); req = 4'b0001; setop(0, 1'b0, 32'h7FFF_FFFF, 32'd1);
        #1 chk("t4_gnt", 32'(gnt), 32'h1);
        @(negedge clk); setop(0, 1'b1, 32'h8000_0000, 32'd1);
        #1 chk("t4_gnt2", 32'(gnt), 32'h1);
        chk("t4_add_ovf", res, EXP_ADD_OVF);
        @(negedge clk); req = 4'b0000;
        #1 chk("t4_sub_ovf", res, EXP_SUB_OVF);

        // Reset while holding a result; pointer returns to 0
        @(negedge clk); rst = 1'b1; req = 4'b0011;
        setop(0, 1'b0, 32'd2, 32'd3); setop(1, 1'b0, 32'd4, 32'd4);
        #1 chk("t5_rst_gnt", 32'(gnt), 32'h0);
        @(negedge clk); rst = 1'b0;
        #1 chk("t5_valid", 32'(valid), 32'h0);
        chk("t5_id", 32'(id), 32'h0);
        chk("t5_res", res, 32'h0);
        chk("t5_gnt0", 32'(gnt), 32'h1);
        @(negedge clk);
        #1 chk("t5_res0", res, 32'd5);
        chk("t5_gnt1", 32'(gnt), 32'h2);
        @(negedge clk); req = 4'b0000;
        #1 chk("t5_id1", 32'(id), 32'h1);
        chk("t5_res1", res, 32'd8);
        @(negedge clk);
        #1 chk("t5_idle", 32'(valid), 32'h0);

        // Only requester 3 for four accepts; pointer wraps to 0 each time
        @(negedge clk); req = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            setop(3, 1'b1, 32'd50, 32'(i));
            #1 chk("t6_gnt", 32'(gnt), 32'h8);
            if (i > 0) begin
                chk("t6_id", 32'(id), 32'h3);
                chk("t6_res", res, 32'(50 - (i - 1)));
            end
            @(negedge clk);
        end
        req = 4'b1001; setop(0, 1'b0, 32'd1, 32'd1);
        #1 chk("t6_ptr0_gnt", 32'(gnt), 32'h1);
        chk("t6_last_id", 32'(id), 32'h3);
        chk("t6_last_res", res, 32'd47);
        @(negedge clk); req = 4'b0000;
        #1 chk("t6_fin_id", 32'(id), 32'h0);
        chk("t6_fin_res", res, 32'd2);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
